data_mem_unit: RTL

Byte-addressable, parametrised data memory for the RV64 datapath, replacing the word-indexed data memory. It supports RISC-V load/store sizes (byte/half/word/double) with sign or zero extension and detects misaligned and illegal accesses. It uses a valid/ready request and response handshake with configurable read latency, and clears its contents with a hardware sweep after reset. It sits between the execute/memory stage and the writeback mux.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/data_mem_unit_if.sv | 33 +++
 rtl/mem_lane_align.sv | 68 ++++++
 rtl/data_mem_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory.
//   F3_*        : RISC-V load/store funct3 encodings
//   state_t     : controller states (INIT sweep, IDLE, WAIT for latency, RESP)
//   size_bytes  : access size in bytes from funct3[1:0]
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            2'd0:    n = 4'd1;
            2'd1:    n = 4'd2;
            2'd2:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus of the data memory.
//   master : memory-stage side (drives requests, accepts responses)
//   slave  : data_mem_unit side
//   req_*  : valid/ready request with store flag, byte address, funct3, store data
//   rsp_*  : valid/ready response with extended load data and error flag
interface data_mem_unit_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH * XLEN / 8);

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for one 64-bit memory word.
//   we        in  : 1 = store, 0 = load
//   offset    in  : byte offset within the word (addr[2:0])
//   funct3    in  : RISC-V load/store funct3
//   wdata     in  : right-aligned store data
//   rword     in  : addressed memory word
//   byte_en   out : store byte enables (all zero on error or load)
//   wdata_sh  out : store data shifted into its lanes
//   load_data out : extracted, sign/zero-extended load data (zero on store/error)
//   err       out : misaligned or illegal access
module mem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              we,
    input  logic [2:0]        offset,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rword,
    output logic [XLEN/8-1:0] byte_en,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [XLEN-1:0]   load_data,
    output logic              err
);

    localparam int NB = XLEN / 8;

    logic [3:0]      size;
    logic            illegal;
    logic            misaligned;
    logic [NB-1:0]   lane_mask;
    logic [XLEN-1:0] shifted;

    always_comb begin
        size       = size_bytes(funct3[1:0]);
        illegal    = we ? funct3[2] : (funct3 == 3'b111);
        misaligned = (({1'b0, offset}) & (size - 4'd1)) != 4'd0;
        err        = illegal | misaligned;

        case (funct3[1:0])
            2'd0:    lane_mask = NB'(8'h01);
            2'd1:    lane_mask = NB'(8'h03);
            2'd2:    lane_mask = NB'(8'h0F);
            default: lane_mask = NB'(8'hFF);
        endcase

        // Enables are forced low on error so a bad store never touches memory.
        byte_en  = (we && !err) ? (lane_mask << offset) : '0;
        wdata_sh = wdata << {offset, 3'b000};

        shifted = rword >> {offset, 3'b000};
        case (funct3)
            F3_B:    load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_D:    load_data = shifted;
            F3_BU:   load_data = {{(XLEN-8){1'b0}},  shifted[7:0]};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_WU:   load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: load_data = '0;
        endcase
        if (we || err) begin
            load_data = '0;
        end
    end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressable RV64 data memory with valid/ready request/response,
// configurable read latency and a zeroing sweep after reset.
//   clk   in : clock, rising edge
//   rst_n in : asynchronous active-low reset
//   bus      : data_mem_unit_if.slave (req_valid/ready/we/addr/funct3/wdata,
//              rsp_valid/ready/rdata/err)
// Parameters: XLEN (64), DEPTH (words, power of 2), RD_LAT (1..4).
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_unit_if.slave bus
);

    localparam int AW = $clog2(DEPTH * XLEN / 8);
    localparam int WW = AW - 3;
    localparam int NB = XLEN / 8;
    localparam int LW = 2;

    state_t          state;
    logic [WW-1:0]   cnt;
    logic [LW-1:0]   lat_cnt;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;

    logic [XLEN-1:0] mem [DEPTH];

    logic [WW-1:0]   word_idx;
    logic [XLEN-1:0] rd_word;
    logic [NB-1:0]   byte_en;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] load_data;
    logic            err;
    logic            accept;

    assign word_idx = bus.req_addr[AW-1:3];
    assign rd_word  = mem[word_idx];
    assign accept   = (state == IDLE) && bus.req_valid;

    mem_lane_align #(
        .XLEN(XLEN)
    ) u_lane (
        .we        (bus.req_we),
        .offset    (bus.req_addr[2:0]),
        .funct3    (bus.req_funct3),
        .wdata     (bus.req_wdata),
        .rword     (rd_word),
        .byte_en   (byte_en),
        .wdata_sh  (wdata_sh),
        .load_data (load_data),
        .err       (err)
    );

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Storage has no reset; the INIT sweep clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else if (accept && bus.req_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    // Load data is captured at acceptance and simply held through WAIT/RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            cnt         <= '0;
            lat_cnt     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + WW'(1);
                    if (cnt == WW'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (bus.req_valid) begin
                        rsp_rdata_q <= load_data;
                        rsp_err_q   <= err;
                        if (RD_LAT == 1) begin
                            state <= RESP;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= LW'(RD_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == LW'(1)) begin
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
